// File: rtl/hms_bcd_formatter_pkg.sv
// Shared constants and types for the HMS-to-BCD formatter: packed-time field
// positions, the segment-decoder blank code, the sequencer state enum and
// the position of each digit inside the 24-bit digit bus.
package hms_fmt_pkg;

  // Packed time layout: {1'b0, hours[6:0], minutes[5:0], seconds[5:0]}
  localparam int HRS_LSB = 12;
  localparam int HRS_W   = 7;
  localparam int MIN_LSB = 6;
  localparam int MIN_W   = 6;
  localparam int SEC_LSB = 0;
  localparam int SEC_W   = 6;

  // Converter output: hundreds, tens and ones nibbles
  localparam int BCD_W = 12;

  // Nibble value the segment decoder renders as a dark digit
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Digit index inside bcd_digits; digit i occupies bits [4*i +: 4]
  localparam int DIG_S1  = 0;
  localparam int DIG_S10 = 1;
  localparam int DIG_M1  = 2;
  localparam int DIG_M10 = 3;
  localparam int DIG_H1  = 4;
  localparam int DIG_H10 = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV_H = 3'd1,
    ST_CONV_M = 3'd2,
    ST_CONV_S = 3'd3,
    ST_DONE   = 3'd4
  } fmt_state_e;

endpackage

// File: rtl/hms_bcd_formatter_bin2bcd_seq.sv
// Sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
// load places the binary value in the low bits of a scratch register and
// clears the BCD accumulator; each shift_en cycle adjusts every BCD nibble
// that is >= 5 by +3 and then shifts the whole scratch left by one. After
// BIN_W shift cycles, result holds the BCD value. Sequencing is the parent's job.
module bin2bcd_seq #(
  parameter int BIN_W = 7,
  parameter int BCD_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [BIN_W-1:0] value,
  output logic [BCD_W-1:0] result
);

  localparam int SCR_W  = BCD_W + BIN_W;
  localparam int N_DIGS = BCD_W / 4;

  logic [SCR_W-1:0] r_scratch;
  logic [SCR_W-1:0] w_adjusted;

  // Add 3 to every BCD nibble that would overflow past 9 after doubling
  always_comb begin
    w_adjusted = r_scratch;
    for (int d = 0; d < N_DIGS; d++) begin
      if (r_scratch[BIN_W + 4*d +: 4] >= 4'd5) begin
        w_adjusted[BIN_W + 4*d +: 4] = r_scratch[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  // Scratch register: load has priority over shift
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_scratch <= '0;
    end else if (load) begin
      r_scratch <= {{BCD_W{1'b0}}, value};
    end else if (shift_en) begin
      r_scratch <= w_adjusted << 1;
    end
  end

  assign result = r_scratch[SCR_W-1 -: BCD_W];

endmodule

// File: rtl/hms_bcd_formatter.sv
// HMS-to-BCD formatter. Snapshots packed HMS time on each accepted
// half-second strobe and converts hours, minutes and seconds into six BCD
// digits through one shared sequential converter (8 cycles per field).
// Hours above 99 saturate to 99 and raise hrs_overflow. colon_on toggles on
// every half-second strobe for the display's blinking colon.
// Optional build macro LEADING_ZERO_BLANK_EN: a zero hours-tens digit is
// replaced by the blank code so the display shows " 1:23:45".
//
// Strobe semantics: half_sec_pulse is a single-cycle strobe sampled on the
// rising clock edge; there is no back-pressure. A strobe with hold=0 starts a
// conversion when idle, or is remembered in a 1-deep pending flag when busy.
// digits_valid is a single-cycle pulse in the cycle bcd_digits changes.
module hms_bcd_formatter
  import hms_fmt_pkg::*;
#(
  parameter int BIN_W   = 7,
  parameter int LATENCY = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] hms_time,
  input  logic        half_sec_pulse,
  input  logic        hold,
  output logic [23:0] bcd_digits,
  output logic        digits_valid,
  output logic        busy,
  output logic        hrs_overflow,
  output logic        colon_on
);

  // Each field phase spans a third of the trigger-to-valid latency
  localparam int PHASE_LEN = LATENCY / 3;
  localparam int CNT_W     = $clog2(PHASE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_LEN - 1);

  fmt_state_e       r_state;
  fmt_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic [11:0]      r_snap_ms;
  logic [7:0]       r_hrs_bcd;
  logic             r_hrs_ovf;
  logic [7:0]       r_min_bcd;
  logic [23:0]      r_bcd_digits;
  logic             r_valid;
  logic             r_hrs_overflow;
  logic             r_colon;

  logic             w_trigger;
  logic             w_phase_last;
  logic             w_busy;
  logic             w_start;
  logic             w_conv_load;
  logic             w_conv_shift;
  logic [BIN_W-1:0] w_conv_value;
  logic             w_finish;
  logic [BCD_W-1:0] w_conv_result;
  logic [3:0]       w_h10;
  logic             w_unused_bit19;

  assign w_unused_bit19 = hms_time[19];
  assign w_trigger      = half_sec_pulse & ~hold;
  assign w_phase_last   = (r_cnt == CNT_LAST);
  assign w_busy         = (r_state == ST_CONV_H) || (r_state == ST_CONV_M) ||
                          (r_state == ST_CONV_S);

  // Next state plus converter control; hours are loaded straight from the
  // live input on the start edge, the same edge that snapshots min/sec
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_conv_load  = 1'b0;
    w_conv_shift = 1'b0;
    w_conv_value = '0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_next_state = ST_CONV_H;
          w_start      = 1'b1;
          w_conv_load  = 1'b1;
          w_conv_value = BIN_W'(hms_time[HRS_LSB +: HRS_W]);
        end
      end
      ST_CONV_H: begin
        w_conv_shift = ~w_phase_last;
        if (w_phase_last) begin
          w_next_state = ST_CONV_M;
          w_conv_load  = 1'b1;
          w_conv_value = BIN_W'(r_snap_ms[MIN_LSB +: MIN_W]);
        end
      end
      ST_CONV_M: begin
        w_conv_shift = ~w_phase_last;
        if (w_phase_last) begin
          w_next_state = ST_CONV_S;
          w_conv_load  = 1'b1;
          w_conv_value = BIN_W'(r_snap_ms[SEC_LSB +: SEC_W]);
        end
      end
      ST_CONV_S: begin
        w_conv_shift = ~w_phase_last;
        if (w_phase_last) begin
          w_next_state = ST_DONE;
          w_finish     = 1'b1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
        if (r_pending || w_trigger) begin
          w_next_state = ST_CONV_H;
          w_start      = 1'b1;
          w_conv_load  = 1'b1;
          w_conv_value = BIN_W'(hms_time[HRS_LSB +: HRS_W]);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Cycle-within-phase counter, restarted on every state change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Pending flag: merges any number of triggers seen while converting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end else if (w_trigger && w_busy) begin
      r_pending <= 1'b1;
    end
  end

  // Minutes/seconds snapshot, isolating the result from later input changes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_snap_ms <= '0;
    end else if (w_start) begin
      r_snap_ms <= hms_time[11:0];
    end
  end

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .clock    (clock),
    .reset    (reset),
    .load     (w_conv_load),
    .shift_en (w_conv_shift),
    .value    (w_conv_value),
    .result   (w_conv_result)
  );

  // Capture hours (with saturation) and minutes at the end of their phases
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hrs_bcd <= '0;
      r_hrs_ovf <= 1'b0;
      r_min_bcd <= '0;
    end else begin
      if ((r_state == ST_CONV_H) && w_phase_last) begin
        r_hrs_ovf <= (w_conv_result[11:8] != 4'd0);
        r_hrs_bcd <= (w_conv_result[11:8] != 4'd0) ? 8'h99 : w_conv_result[7:0];
      end
      if ((r_state == ST_CONV_M) && w_phase_last) begin
        r_min_bcd <= w_conv_result[7:0];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_h10 = (r_hrs_bcd[7:4] == 4'd0) ? BCD_BLANK : r_hrs_bcd[7:4];
`else
  assign w_h10 = r_hrs_bcd[7:4];
`endif

  // Output digit register and valid strobe, updated as seconds complete
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bcd_digits   <= '0;
      r_valid        <= 1'b0;
      r_hrs_overflow <= 1'b0;
    end else begin
      r_valid <= w_finish;
      if (w_finish) begin
        r_bcd_digits[4*DIG_H10 +: 4] <= w_h10;
        r_bcd_digits[4*DIG_H1  +: 4] <= r_hrs_bcd[3:0];
        r_bcd_digits[4*DIG_M10 +: 4] <= r_min_bcd[7:4];
        r_bcd_digits[4*DIG_M1  +: 4] <= r_min_bcd[3:0];
        r_bcd_digits[4*DIG_S10 +: 4] <= w_conv_result[7:4];
        r_bcd_digits[4*DIG_S1  +: 4] <= w_conv_result[3:0];
        r_hrs_overflow               <= r_hrs_ovf;
      end
    end
  end

  // Colon blink: toggles on every strobe regardless of hold or busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_colon <= 1'b1;
    end else if (half_sec_pulse) begin
      r_colon <= ~r_colon;
    end
  end

  assign bcd_digits   = r_bcd_digits;
  assign digits_valid = r_valid;
  assign busy         = w_busy;
  assign hrs_overflow = r_hrs_overflow;
  assign colon_on     = r_colon;

endmodule

// File: tb/tb_hms_bcd_formatter.sv
// Directed bench for hms_bcd_formatter: reset values, basic conversion and
// latency, hours saturation, pending-trigger merge, hold behaviour and reset
// in the middle of a conversion. Expected digits honour LEADING_ZERO_BLANK_EN.
module tb_hms_bcd_formatter;

  logic        clock;
  logic        reset;
  logic [19:0] hms_time;
  logic        half_sec_pulse;
  logic        hold;
  logic [23:0] bcd_digits;
  logic        digits_valid;
  logic        busy;
  logic        hrs_overflow;
  logic        colon_on;

  int          n_vec;
  int          n_err;
  logic        exp_colon;
  logic [23:0] exp_q[$];
  logic [23:0] last_digits;

  hms_bcd_formatter dut (
    .clock          (clock),
    .reset          (reset),
    .hms_time       (hms_time),
    .half_sec_pulse (half_sec_pulse),
    .hold           (hold),
    .bcd_digits     (bcd_digits),
    .digits_valid   (digits_valid),
    .busy           (busy),
    .hrs_overflow   (hrs_overflow),
    .colon_on       (colon_on)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] hms(input int h, input int m, input int s);
    return {1'b0, 7'(h), 6'(m), 6'(s)};
  endfunction

  // Display model: zero hours-tens becomes the blank code in blanking builds
  function automatic logic [23:0] disp(input logic [23:0] raw);
    logic [23:0] d;
    d = raw;
`ifdef LEADING_ZERO_BLANK_EN
    if (d[23:20] == 4'd0) d[23:20] = 4'hF;
`endif
    return d;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single-cycle strobe; returns 1 time unit after the sampling edge
  task automatic pulse_once();
    half_sec_pulse = 1'b1;
    @(posedge clock);
    #1;
    half_sec_pulse = 1'b0;
    exp_colon = ~exp_colon;
  endtask

  // Bounded wait for digits_valid; reports cycles after the strobe edge
  task automatic wait_valid(input int max_cycles, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < max_cycles) begin
      tick();
      cycles++;
      if (digits_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int  cyc;
    bit  seen;
    reset = 1'b0; hold = 1'b0; half_sec_pulse = 1'b0; hms_time = '0;
    exp_colon = 1'b1;
    repeat (3) tick();
    n_vec++; if (bcd_digits !== 24'h0) begin n_err++; $display("FAIL reset_digits got %h want %h", bcd_digits, 24'h0); end
    n_vec++; if (digits_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", digits_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (hrs_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", hrs_overflow); end
    n_vec++; if (colon_on !== 1'b1) begin n_err++; $display("FAIL reset_colon got %b want 1", colon_on); end
    reset = 1'b1;
    repeat (2) tick();
    pulse_once();
    n_vec++; if (colon_on !== 1'b0) begin n_err++; $display("FAIL reset_colon_toggle got %b want 0", colon_on); end
    wait_valid(40, cyc, seen);
    n_vec++; if (!seen || cyc != 24) begin n_err++; $display("FAIL reset_first_conv seen %0d after %0d want 24", seen, cyc); end
    n_vec++; if (bcd_digits !== disp(24'h000000)) begin n_err++; $display("FAIL reset_first_digits got %h want %h", bcd_digits, disp(24'h000000)); end
    last_digits = disp(24'h000000);
    tick();
  endtask

  task automatic test_basic();
    logic [23:0] exp;
    int          busy_bad;
    int          valid_bad;
    busy_bad  = 0;
    valid_bad = 0;
    exp = disp(24'h012345);
    hms_time = hms(1, 23, 45);
    pulse_once();
    for (int k = 1; k <= 23; k++) begin
      if (k == 2) hms_time = hms(9, 9, 9);
      tick();
      if (busy !== 1'b1) busy_bad++;
      if (digits_valid !== 1'b0) valid_bad++;
    end
    n_vec++; if (busy_bad != 0) begin n_err++; $display("FAIL basic_busy_window low in %0d cycles want 0", busy_bad); end
    n_vec++; if (valid_bad != 0) begin n_err++; $display("FAIL basic_early_valid high in %0d cycles want 0", valid_bad); end
    tick();
    n_vec++; if (digits_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_t24 got %b want 1", digits_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_t24 got %b want 0", busy); end
    n_vec++; if (bcd_digits !== exp) begin n_err++; $display("FAIL basic_digits got %h want %h", bcd_digits, exp); end
    n_vec++; if (hrs_overflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", hrs_overflow); end
    tick();
    n_vec++; if (digits_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_t25 got %b want 0", digits_valid); end
    last_digits = exp;
  endtask

  task automatic test_saturation();
    int cyc;
    bit seen;
    hms_time = hms(105, 59, 0);
    pulse_once();
    wait_valid(40, cyc, seen);
    n_vec++; if (!seen || cyc != 24) begin n_err++; $display("FAIL sat_latency seen %0d after %0d want 24", seen, cyc); end
    n_vec++; if (bcd_digits !== 24'h995900) begin n_err++; $display("FAIL sat_digits got %h want %h", bcd_digits, 24'h995900); end
    n_vec++; if (hrs_overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", hrs_overflow); end
    tick();
    hms_time = hms(99, 12, 34);
    pulse_once();
    wait_valid(40, cyc, seen);
    n_vec++; if (!seen || cyc != 24) begin n_err++; $display("FAIL sat99_latency seen %0d after %0d want 24", seen, cyc); end
    n_vec++; if (bcd_digits !== 24'h991234) begin n_err++; $display("FAIL sat99_digits got %h want %h", bcd_digits, 24'h991234); end
    n_vec++; if (hrs_overflow !== 1'b0) begin n_err++; $display("FAIL sat99_ovf got %b want 0", hrs_overflow); end
    tick();
    hms_time = hms(7, 63, 60);
    pulse_once();
    wait_valid(40, cyc, seen);
    n_vec++; if (bcd_digits !== disp(24'h076360)) begin n_err++; $display("FAIL literal_6x got %h want %h", bcd_digits, disp(24'h076360)); end
    last_digits = disp(24'h076360);
    tick();
  endtask

  task automatic test_pending();
    int          n_valid;
    int          at_k[2];
    logic [23:0] got[2];
    logic [23:0] exp;
    n_valid = 0;
    at_k[0] = -1; at_k[1] = -1;
    got[0] = 'x; got[1] = 'x;
    exp_q.push_back(disp(24'h012345));
    exp_q.push_back(disp(24'h020007));
    hms_time = hms(1, 23, 45);
    pulse_once();
    for (int k = 1; k <= 60; k++) begin
      half_sec_pulse = (k == 5 || k == 10);
      if (k == 8) hms_time = hms(2, 0, 7);
      @(posedge clock);
      #1;
      if (half_sec_pulse) exp_colon = ~exp_colon;
      half_sec_pulse = 1'b0;
      if (digits_valid === 1'b1) begin
        if (n_valid < 2) begin
          at_k[n_valid] = k;
          got[n_valid]  = bcd_digits;
        end
        n_valid++;
      end
    end
    n_vec++; if (n_valid != 2) begin n_err++; $display("FAIL pend_count got %0d want 2", n_valid); end
    n_vec++; if (at_k[0] != 24) begin n_err++; $display("FAIL pend_first_time got %0d want 24", at_k[0]); end
    n_vec++; if (at_k[1] != 49) begin n_err++; $display("FAIL pend_second_time got %0d want 49", at_k[1]); end
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      n_vec++; if (got[i] !== exp) begin n_err++; $display("FAIL pend_digits_%0d got %h want %h", i, got[i], exp); end
    end
    n_vec++; if (colon_on !== exp_colon) begin n_err++; $display("FAIL pend_colon got %b want %b", colon_on, exp_colon); end
    last_digits = disp(24'h020007);
  endtask

  task automatic test_hold();
    int cyc;
    bit seen;
    int extra;
    hold = 1'b1;
    hms_time = hms(11, 11, 11);
    pulse_once();
    wait_valid(30, cyc, seen);
    n_vec++; if (seen) begin n_err++; $display("FAIL hold_no_valid got valid after %0d want none", cyc); end
    n_vec++; if (bcd_digits !== last_digits) begin n_err++; $display("FAIL hold_digits got %h want %h", bcd_digits, last_digits); end
    n_vec++; if (colon_on !== exp_colon) begin n_err++; $display("FAIL hold_colon got %b want %b", colon_on, exp_colon); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_busy got %b want 0", busy); end
    hold = 1'b0;
    hms_time = hms(12, 34, 56);
    pulse_once();
    wait_valid(40, cyc, seen);
    n_vec++; if (!seen || cyc != 24) begin n_err++; $display("FAIL hold_release_latency seen %0d after %0d want 24", seen, cyc); end
    n_vec++; if (bcd_digits !== 24'h123456) begin n_err++; $display("FAIL hold_release_digits got %h want %h", bcd_digits, 24'h123456); end
    tick();
    // hold raised mid-conversion: the running conversion still completes,
    // and a strobe under hold does not queue another one
    hms_time = hms(23, 59, 58);
    pulse_once();
    repeat (2) tick();
    hold = 1'b1;
    repeat (7) tick();
    pulse_once();
    wait_valid(40, cyc, seen);
    n_vec++; if (!seen || cyc != 14) begin n_err++; $display("FAIL hold_mid_latency seen %0d after %0d want 14", seen, cyc); end
    n_vec++; if (bcd_digits !== 24'h235958) begin n_err++; $display("FAIL hold_mid_digits got %h want %h", bcd_digits, 24'h235958); end
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (digits_valid === 1'b1 || busy === 1'b1) extra++;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL hold_no_pending got %0d active cycles want 0", extra); end
    hold = 1'b0;
    last_digits = 24'h235958;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    int late;
    hms_time = hms(105, 1, 2);
    pulse_once();
    wait_valid(40, cyc, seen);
    tick();
    hms_time = hms(7, 8, 9);
    pulse_once();
    repeat (12) tick();
    reset = 1'b0;
    exp_colon = 1'b1;
    #1;
    n_vec++; if (bcd_digits !== 24'h0) begin n_err++; $display("FAIL rmid_digits got %h want %h", bcd_digits, 24'h0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_vec++; if (hrs_overflow !== 1'b0) begin n_err++; $display("FAIL rmid_ovf got %b want 0", hrs_overflow); end
    n_vec++; if (colon_on !== 1'b1) begin n_err++; $display("FAIL rmid_colon got %b want 1", colon_on); end
    repeat (2) tick();
    reset = 1'b1;
    late = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (digits_valid === 1'b1) late++;
    end
    n_vec++; if (late != 0) begin n_err++; $display("FAIL rmid_no_valid got %0d pulses want 0", late); end
    pulse_once();
    wait_valid(40, cyc, seen);
    n_vec++; if (!seen || cyc != 24) begin n_err++; $display("FAIL rmid_after_latency seen %0d after %0d want 24", seen, cyc); end
    n_vec++; if (bcd_digits !== disp(24'h070809)) begin n_err++; $display("FAIL rmid_after_digits got %h want %h", bcd_digits, disp(24'h070809)); end
    n_vec++; if (colon_on !== exp_colon) begin n_err++; $display("FAIL rmid_after_colon got %b want %b", colon_on, exp_colon); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_pending();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hms_bcd_formatter.md
Name: hms_bcd_formatter

Overview:
Downstream consumer of the timing block's packed HMS time and half-second pulse. It snapshots the time on each half-second strobe and converts hours, minutes and seconds to six BCD digits. Conversion is sequential (shift-and-add-3), one bit per cycle, through one shared converter. It also drives a colon-blink flag for the display driver that follows.

Parameters:
BIN_W, 7, width of the shared binary-to-BCD converter input (the hours width).
LATENCY, 24, cycles from accepted trigger to digits_valid (fixed, informational; equals 3 x (1 + BIN_W) + 0).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
hms_time  in  20  bit 19 = 0; [18:12] hours 0..127; [11:6] minutes 0..63; [5:0] seconds 0..63
half_sec_pulse  in  1  single-cycle strobe; conversion trigger and colon toggle
hold  in  1  1 = freeze displayed digits (lap view)
bcd_digits  out  24  {H10,H1,M10,M1,S10,S1}, 4 bits each
digits_valid  out  1  single-cycle pulse when bcd_digits updates
busy  out  1  conversion in progress
hrs_overflow  out  1  last converted hours value was greater than 99
colon_on  out  1  colon segment enable

Behaviour:
- Reset (reset=0, async): bcd_digits=0, digits_valid=0, busy=0, hrs_overflow=0, colon_on=1, FSM=IDLE, pending=0.
- colon_on toggles on every half_sec_pulse, independent of hold and busy.
- Trigger = half_sec_pulse && !hold.
- FSM states: IDLE, CONV_H, CONV_M, CONV_S, DONE.
- IDLE + trigger at edge T:
  - snapshot hms_time into an internal register.
  - go to CONV_H; busy=1 from T+1.
- Each CONV_x state lasts BIN_W+1 = 8 cycles:
  - cycle 0 loads the field, zero-extended to 7 bits, and clears the BCD accumulator.
  - cycles 1..7 each perform add-3 (on any nibble >=5) then shift left by 1.
- CONV_H to CONV_M to CONV_S in sequence, then DONE.
- DONE lasts 1 cycle; bcd_digits and digits_valid are registered so they appear at T+24. Return to IDLE; busy=0 in the same cycle digits_valid=1.
- Hours saturation:
  - converter result above 99 (hundreds nibble nonzero): H10,H1 = 9,9 and hrs_overflow=1.
  - otherwise hrs_overflow=0.
  - Minutes/seconds are converted literally; 60..63 show as 6x. No clamping.
- Trigger while busy: sets a 1-deep pending flag; extra triggers are merged.
  - In the DONE cycle, if pending=1, clear it, take a fresh snapshot and go straight to CONV_H. Next digits_valid comes 25 cycles after the previous one.
- hold=1:
  - new triggers are ignored; pending is not set.
  - a conversion already in progress completes and updates the outputs.
- Reset mid-conversion: outputs immediately return to reset values; the partial result is discarded.
- Snapshot isolation: hms_time changes during a conversion do not affect the result.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: when H10==0, output nibble H10=4'hF (blank code for the segment decoder). Other digits are unaffected.
- Undefined: H10 outputs 0 normally.

Decomposition:
- Package hms_fmt_pkg holds:
  - field LSB/MSB constants (HRS_LSB=12, MIN_LSB=6, SEC_LSB=0, widths 7/6/6).
  - BCD_BLANK=4'hF.
  - the FSM state enum.
  - the digit-index constants.
- One sub-module, bin2bcd_seq: 7-bit input, 12-bit BCD output.
  - ports: load, shift enable, value, result.
  - purely a datapath register plus add-3 logic; sequencing stays in the parent.

Test Plan:
- Reset values: hold reset low, release; check outputs = 0,0,0,0 and colon_on=1. A half_sec_pulse toggles colon_on to 0.
- Basic conversion: hms_time=01:23:45, i.e. {1'b0,7'd1,6'd23,6'd45}, pulse at T. Expect bcd_digits=24'h012345 and digits_valid at T+24 only, busy high T+1..T+23. With LEADING_ZERO_BLANK_EN expect 24'hF12345.
- Saturation: hours=105, min=59, sec=0. Expect 24'h995900 and hrs_overflow=1. A next conversion with hours=99 gives hrs_overflow=0.
- Pending merge: pulse at T, two more pulses at T+5 and T+10, hms_time changed at T+8 to 02:00:07. Expect 2 digits_valid pulses, the second at T+49 with 24'h020007.
- Hold: hold=1, pulse. No digits_valid, digits unchanged, colon_on still toggles. Release hold and pulse; conversion occurs normally.
- Reset mid-conversion: assert reset at T+12. Outputs clear immediately and no digits_valid follows. After release, a new pulse converts correctly.
